nn_inference_sequencer: RTL and testbench
=========================================

Name: nn_inference_sequencer

Overview:
- Top-level scheduler for one MNIST inference pass.
- On a host command it starts the image loader and the first layer engine together, then counts pixel beats on the loader's x stream.
- Layer engines are chained strictly in order: each layer_done starts the next. The final layer's class index is captured.
- Sits between the AXI-lite control registers (cmd/status) and the image loader plus layer engines. Observes the x stream passively and never drives it.

Parameters:
- NUM_PIXELS, 784, x-stream beats expected per image (one beat per x_tvalid && x_tready).
- NUM_LAYERS, 3, number of chained layer engines (1..8).
- CLASS_W, 4, width of the class index.
- TIMEOUT_CYCLES, 100000, watchdog limit in cycles (used only with WATCHDOG_EN).

Ports:
- s_axi_aclk  in  1  clock.
- s_axi_areset  in  1  synchronous active-high reset.
- cmd_start  in  1  single-cycle start request from the control register.
- cmd_abort  in  1  single-cycle abort request.
- x_tvalid  in  1  tap of the loader stream valid.
- x_tready  in  1  tap of the loader stream ready.
- layer_done  in  NUM_LAYERS  per-layer single-cycle completion pulse.
- class_in  in  CLASS_W  class index from the last layer; valid while layer_done[NUM_LAYERS-1] is high.
- loader_start  out  1  one-cycle start pulse to the image loader.
- layer_start  out  NUM_LAYERS  one-hot, one-cycle start pulse per layer.
- busy  out  1  high while a pass is in progress.
- done  out  1  one-cycle pulse when a pass completes successfully.
- error  out  1  sticky error flag.
- err_code  out  2  0 none, 1 short image, 2 long image, 3 timeout.
- class_out  out  CLASS_W  captured result.
- cycle_count  out  32  cycles spent in the last or current pass.

Behaviour:
- All outputs are registered. Reset values are 0 for every output.
- Reset is synchronous, sampled on the s_axi_aclk rising edge. Reset mid-pass returns to IDLE immediately and emits no done or start pulses.
- States: IDLE, RUN, DONE, ERR. Internal registers: layer_idx (3 bits), beat_cnt (16 bits, saturating).
- IDLE:
  - cmd_start high and cmd_abort low at edge k → at k+1: loader_start=1, layer_start[0]=1, busy=1; beat_cnt, layer_idx and cycle_count cleared; go to RUN.
  - cmd_start and cmd_abort both high → the start is ignored.
- RUN:
  - cycle_count increments every cycle and saturates at 0xFFFFFFFF.
  - beat_cnt increments on every x_tvalid && x_tready.
  - A beat arriving when beat_cnt == NUM_PIXELS → ERR with code 2.
  - layer_done[layer_idx] with layer_idx == 0 and beat_cnt (including any beat in the same cycle) != NUM_PIXELS → ERR with code 1.
  - layer_done[layer_idx] otherwise:
    - If layer_idx < NUM_LAYERS-1: increment layer_idx; layer_start[layer_idx+1] is high the next cycle for one cycle.
    - If layer_idx == NUM_LAYERS-1: class_out ← class_in; go to DONE.
  - layer_done bits for any index other than layer_idx are ignored.
  - cmd_start in RUN is ignored.
  - cmd_abort in RUN → IDLE next cycle with busy=0 and no done. error is unchanged and class_out is retained.
  - If cmd_abort and a layer_done occur in the same cycle, abort wins.
- DONE: done=1 for exactly one cycle and busy=0 in that cycle, then IDLE. class_out and cycle_count hold until the next start.
- ERR: busy=0, error=1, err_code held. Leave ERR only via cmd_start (same actions as IDLE start; also clears error and err_code) or reset. cmd_abort in ERR has no effect.
- Latencies:
  - cmd_start to loader_start: 1 cycle.
  - Final layer_done to done and class_out valid: 1 cycle.
  - layer_done[i] to layer_start[i+1]: 1 cycle.
- Exactly one pass is in flight at a time. No command queuing.

Optional Feature:
- WATCHDOG_EN defined: a 32-bit idle counter clears on start, on every x beat and on every accepted layer_done. It increments in RUN otherwise. When it reaches TIMEOUT_CYCLES → ERR with code 3.
- WATCHDOG_EN undefined: the counter is not built and err_code never equals 3. A stalled pass stays in RUN until cmd_abort or reset.

Test Plan:
- Nominal pass (NUM_PIXELS=5, NUM_LAYERS=3): start, 5 beats, then done pulses on layer 0, 1, 2 with class_in=7 → layer_start sequence 001, 010, 100 one cycle after each prior event; done pulse; class_out=7; error=0.
- Short image: 4 beats, then layer_done[0] → error=1, err_code=1, busy=0, no layer_start[1].
- Long image: 6 beats before layer_done[0] → err_code=2 on the 6th beat. A following cmd_start clears the error and the nominal pass then succeeds.
- Abort mid-pass: cmd_abort after layer 1 starts → busy=0 next cycle, no done; a later layer_done[1] pulse is ignored.
- Reset and spurious inputs: assert reset during RUN → all outputs 0 the next cycle. layer_done[2] in IDLE and cmd_start+cmd_abort together in IDLE → no state change.
- Watchdog (WATCHDOG_EN, TIMEOUT_CYCLES=50): start, then no activity → err_code=3 exactly 50 cycles after the last progress event. Without the macro, busy stays 1 after 200 cycles.

Source files
------------

// File: rtl/nn_inference_sequencer.sv
// Scheduler for one MNIST inference pass: starts the loader and layer 0, counts x beats,
// chains the layer engines and captures the class. Optional watchdog under WATCHDOG_EN.
module nn_inference_sequencer #(
   parameter int NUM_PIXELS     = 784,
   parameter int NUM_LAYERS     = 3,
   parameter int CLASS_W        = 4,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic                  s_axi_aclk,
   input  logic                  s_axi_areset,
   input  logic                  cmd_start,
   input  logic                  cmd_abort,
   input  logic                  x_tvalid,
   input  logic                  x_tready,
   input  logic [NUM_LAYERS-1:0] layer_done,
   input  logic [CLASS_W-1:0]    class_in,
   output logic                  loader_start,
   output logic [NUM_LAYERS-1:0] layer_start,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [1:0]            err_code,
   output logic [CLASS_W-1:0]    class_out,
   output logic [31:0]           cycle_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2,
      ERR  = 2'd3
   } state_t;

   localparam logic [15:0] PIXELS       = 16'(NUM_PIXELS);
   localparam logic [2:0]  LAST_IDX     = 3'(NUM_LAYERS - 1);
   localparam logic [7:0]  FIRST_ONEHOT = 8'h01;
   localparam logic [1:0]  ERR_SHORT    = 2'd1;
   localparam logic [1:0]  ERR_LONG     = 2'd2;

   state_t      state_r;
   logic [2:0]  layer_idx_r;
   logic [15:0] beat_cnt_r;
   logic        beat_s;
   logic        start_ok_s;
   logic        done_hit_s;
   logic [7:0]  done_pad_s;
   logic [7:0]  next_onehot_s;
   logic [15:0] beat_cnt_next_s;

`ifdef WATCHDOG_EN
   localparam logic [1:0]  ERR_TIMEOUT = 2'd3;
   localparam logic [31:0] TIMEOUT_LIM = 32'(TIMEOUT_CYCLES - 1);
   logic [31:0] idle_cnt_r;
`endif

   // Decode the current beat, the awaited layer completion and the saturating beat count.
   always_comb begin
      beat_s        = x_tvalid & x_tready;
      start_ok_s    = cmd_start & ~cmd_abort;
      done_pad_s    = 8'(layer_done);
      done_hit_s    = done_pad_s[layer_idx_r];
      next_onehot_s = 8'h01 << (layer_idx_r + 3'd1);
      if (beat_s && (beat_cnt_r != 16'hFFFF)) begin
         beat_cnt_next_s = beat_cnt_r + 16'd1;
      end else begin
         beat_cnt_next_s = beat_cnt_r;
      end
   end

   // Pass sequencer: state, counters and every registered output.
   always_ff @(posedge s_axi_aclk) begin
      if (s_axi_areset) begin
         state_r      <= IDLE;
         layer_idx_r  <= 3'd0;
         beat_cnt_r   <= 16'd0;
         loader_start <= 1'b0;
         layer_start  <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         error        <= 1'b0;
         err_code     <= 2'd0;
         class_out    <= '0;
         cycle_count  <= 32'd0;
`ifdef WATCHDOG_EN
         idle_cnt_r   <= 32'd0;
`endif
      end else begin
         loader_start <= 1'b0;
         layer_start  <= '0;
         done         <= 1'b0;
         case (state_r)
            IDLE, ERR: begin
               if (start_ok_s) begin
                  state_r      <= RUN;
                  loader_start <= 1'b1;
                  layer_start  <= FIRST_ONEHOT[NUM_LAYERS-1:0];
                  busy         <= 1'b1;
                  beat_cnt_r   <= 16'd0;
                  layer_idx_r  <= 3'd0;
                  cycle_count  <= 32'd0;
                  error        <= 1'b0;
                  err_code     <= 2'd0;
`ifdef WATCHDOG_EN
                  idle_cnt_r   <= 32'd0;
`endif
               end else begin
                  state_r <= state_r;
               end
            end
            RUN: begin
               if (cycle_count != 32'hFFFF_FFFF) begin
                  cycle_count <= cycle_count + 32'd1;
               end else begin
                  cycle_count <= cycle_count;
               end
               beat_cnt_r <= beat_cnt_next_s;
`ifdef WATCHDOG_EN
               if (beat_s || done_hit_s) begin
                  idle_cnt_r <= 32'd0;
               end else begin
                  idle_cnt_r <= idle_cnt_r + 32'd1;
               end
`endif
               // Abort outranks everything, then overrun, then the awaited layer completion.
               if (cmd_abort) begin
                  state_r <= IDLE;
                  busy    <= 1'b0;
               end else if (beat_s && (beat_cnt_r == PIXELS)) begin
                  state_r  <= ERR;
                  busy     <= 1'b0;
                  error    <= 1'b1;
                  err_code <= ERR_LONG;
               end else if (done_hit_s && (layer_idx_r == 3'd0) && (beat_cnt_next_s != PIXELS)) begin
                  state_r  <= ERR;
                  busy     <= 1'b0;
                  error    <= 1'b1;
                  err_code <= ERR_SHORT;
               end else if (done_hit_s && (layer_idx_r != LAST_IDX)) begin
                  layer_idx_r <= layer_idx_r + 3'd1;
                  layer_start <= next_onehot_s[NUM_LAYERS-1:0];
               end else if (done_hit_s) begin
                  class_out <= class_in;
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  state_r   <= DONE;
`ifdef WATCHDOG_EN
               end else if (!beat_s && (idle_cnt_r == TIMEOUT_LIM)) begin
                  state_r  <= ERR;
                  busy     <= 1'b0;
                  error    <= 1'b1;
                  err_code <= ERR_TIMEOUT;
`endif
               end else begin
                  state_r <= RUN;
               end
            end
            DONE: begin
               state_r <= IDLE;
            end
            default: begin
               state_r <= IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nn_inference_sequencer.sv
// Scenario bench for nn_inference_sequencer with NUM_PIXELS=5, NUM_LAYERS=3, TIMEOUT_CYCLES=50;
// layer_start pulses and final classes are scoreboarded against queued expectations.
module tb_nn_inference_sequencer;

   localparam int NP = 5;
   localparam int NL = 3;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_start, cmd_abort, x_tvalid, x_tready;
   logic [NL-1:0] layer_done;
   logic [CW-1:0] class_in;
   logic          loader_start, busy, done, error;
   logic [NL-1:0] layer_start;
   logic [1:0]    err_code;
   logic [CW-1:0] class_out;
   logic [31:0]   cycle_count;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   logic [NL-1:0] exp_ls_q[$];
   logic [CW-1:0] exp_cls_q[$];

   nn_inference_sequencer #(
      .NUM_PIXELS(NP), .NUM_LAYERS(NL), .CLASS_W(CW), .TIMEOUT_CYCLES(50)
   ) dut (
      .s_axi_aclk(clk), .s_axi_areset(rst), .cmd_start(cmd_start), .cmd_abort(cmd_abort),
      .x_tvalid(x_tvalid), .x_tready(x_tready), .layer_done(layer_done), .class_in(class_in),
      .loader_start(loader_start), .layer_start(layer_start), .busy(busy), .done(done),
      .error(error), .err_code(err_code), .class_out(class_out), .cycle_count(cycle_count)
   );

   always #5 clk = ~clk;

   // Scoreboard: every layer_start pulse and every done pulse must match a queued expectation.
   always @(posedge clk) begin
      #1;
      if (layer_start !== 3'b000) begin
         total++;
         if (exp_ls_q.size() == 0) begin
            bad++;
            $display("FAIL layer_start_unexpected got=%b want=none t=%0t", layer_start, $time);
         end else begin
            logic [NL-1:0] e;
            e = exp_ls_q.pop_front();
            if (layer_start !== e) begin
               bad++;
               $display("FAIL layer_start got=%b want=%b t=%0t", layer_start, e, $time);
            end
         end
      end
      if (done === 1'b1) begin
         total++;
         if (exp_cls_q.size() == 0) begin
            bad++;
            $display("FAIL done_unexpected class=%0d t=%0t", class_out, $time);
         end else begin
            logic [CW-1:0] ec;
            ec = exp_cls_q.pop_front();
            if (class_out !== ec) begin
               bad++;
               $display("FAIL class_out got=%0d want=%0d t=%0t", class_out, ec, $time);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_start();
      cmd_start = 1'b1;
      exp_ls_q.push_back(3'b001);
      tick();
      cmd_start = 1'b0;
   endtask

   task automatic beats(input int n);
      for (int i = 0; i < n; i++) begin
         x_tvalid = 1'b1;
         x_tready = 1'b1;
         tick();
         x_tvalid = 1'b1;
         x_tready = 1'b0;
         tick();
      end
      x_tvalid = 1'b0;
      x_tready = 1'b0;
   endtask

   task automatic pulse_layer(input int i, input logic [CW-1:0] cls, input bit expect_accept);
      layer_done = 3'b001 << i;
      class_in   = cls;
      if (expect_accept && i < NL - 1) exp_ls_q.push_back(3'b001 << (i + 1));
      if (expect_accept && i == NL - 1) exp_cls_q.push_back(cls);
      tick();
      layer_done = 3'b000;
      class_in   = 4'd0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      total++;
      if ({loader_start, layer_start, busy, done, error, err_code, class_out, cycle_count} !== 45'd0) begin
         bad++;
         $display("FAIL reset_outputs got busy=%b err=%b code=%0d cls=%0d cc=%0d want=all zero",
                  busy, error, err_code, class_out, cycle_count);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_nominal(input logic [CW-1:0] cls);
      int c0;
      do_start();
      c0 = cyc;
      total++;
      if (loader_start !== 1'b1 || busy !== 1'b1) begin
         bad++;
         $display("FAIL start_pulse got ls=%b busy=%b want 1 1", loader_start, busy);
      end
      tick();
      total++;
      if (loader_start !== 1'b0) begin
         bad++;
         $display("FAIL loader_one_cycle got=%b want=0", loader_start);
      end
      beats(NP);
      pulse_layer(0, 4'd0, 1'b1);
      tick();
      pulse_layer(1, 4'd0, 1'b1);
      tick();
      tick();
      pulse_layer(2, cls, 1'b1);
      total++;
      if (done !== 1'b1 || busy !== 1'b0 || error !== 1'b0 || cycle_count !== 32'(cyc - c0)) begin
         bad++;
         $display("FAIL nominal_done got done=%b busy=%b err=%b cc=%0d want 1 0 0 %0d",
                  done, busy, error, cycle_count, cyc - c0);
      end
      tick();
      total++;
      if (done !== 1'b0 || class_out !== cls || cycle_count !== 32'(cyc - c0 - 1)) begin
         bad++;
         $display("FAIL nominal_hold got done=%b cls=%0d cc=%0d want 0 %0d %0d",
                  done, class_out, cycle_count, cls, cyc - c0 - 1);
      end
   endtask

   task automatic test_short_image();
      do_start();
      beats(NP - 1);
      pulse_layer(0, 4'd0, 1'b0);
      total++;
      if (error !== 1'b1 || err_code !== 2'd1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL short_image got err=%b code=%0d busy=%b want 1 1 0", error, err_code, busy);
      end
      tick();
      tick();
   endtask

   task automatic test_long_image();
      do_start();
      total++;
      if (error !== 1'b0 || err_code !== 2'd0) begin
         bad++;
         $display("FAIL restart_clears got err=%b code=%0d want 0 0", error, err_code);
      end
      beats(NP);
      total++;
      if (error !== 1'b0 || busy !== 1'b1) begin
         bad++;
         $display("FAIL long_before got err=%b busy=%b want 0 1", error, busy);
      end
      x_tvalid = 1'b1;
      x_tready = 1'b1;
      tick();
      x_tvalid = 1'b0;
      x_tready = 1'b0;
      total++;
      if (error !== 1'b1 || err_code !== 2'd2 || busy !== 1'b0) begin
         bad++;
         $display("FAIL long_image got err=%b code=%0d busy=%b want 1 2 0", error, err_code, busy);
      end
      tick();
      test_nominal(4'd11);
   endtask

   task automatic test_abort();
      do_start();
      beats(NP);
      pulse_layer(0, 4'd0, 1'b1);
      tick();
      cmd_abort = 1'b1;
      tick();
      cmd_abort = 1'b0;
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 || class_out !== 4'd11) begin
         bad++;
         $display("FAIL abort got busy=%b done=%b err=%b cls=%0d want 0 0 0 11", busy, done, error, class_out);
      end
      pulse_layer(1, 4'd3, 1'b0);
      pulse_layer(2, 4'd3, 1'b0);
      tick();
      total++;
      if (busy !== 1'b0 || class_out !== 4'd11) begin
         bad++;
         $display("FAIL abort_ignore got busy=%b cls=%0d want 0 11", busy, class_out);
      end
   endtask

   task automatic test_reset_spurious();
      do_start();
      beats(2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total++;
      if ({loader_start, layer_start, busy, done, error, err_code, class_out, cycle_count} !== 45'd0) begin
         bad++;
         $display("FAIL reset_mid_run got busy=%b cls=%0d cc=%0d want all zero", busy, class_out, cycle_count);
      end
      pulse_layer(2, 4'd9, 1'b0);
      tick();
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || class_out !== 4'd0) begin
         bad++;
         $display("FAIL idle_layer_done got busy=%b done=%b cls=%0d want 0 0 0", busy, done, class_out);
      end
      cmd_start = 1'b1;
      cmd_abort = 1'b1;
      tick();
      cmd_start = 1'b0;
      cmd_abort = 1'b0;
      total++;
      if (loader_start !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL start_abort_idle got ls=%b busy=%b want 0 0", loader_start, busy);
      end
      tick();
   endtask

   task automatic test_watchdog();
      do_start();
      beats(NP - 1);
      x_tvalid = 1'b1;
      x_tready = 1'b1;
      tick();
      x_tvalid = 1'b0;
      x_tready = 1'b0;
`ifdef WATCHDOG_EN
      repeat (49) tick();
      total++;
      if (error !== 1'b0 || busy !== 1'b1) begin
         bad++;
         $display("FAIL watchdog_early got err=%b busy=%b want 0 1", error, busy);
      end
      tick();
      total++;
      if (error !== 1'b1 || err_code !== 2'd3 || busy !== 1'b0) begin
         bad++;
         $display("FAIL watchdog got err=%b code=%0d busy=%b want 1 3 0", error, err_code, busy);
      end
`else
      repeat (200) tick();
      total++;
      if (busy !== 1'b1 || error !== 1'b0) begin
         bad++;
         $display("FAIL stall_stays_busy got busy=%b err=%b want 1 0", busy, error);
      end
      cmd_abort = 1'b1;
      tick();
      cmd_abort = 1'b0;
`endif
      tick();
   endtask

   initial begin
      #500000;
      $display("FAIL time_limit expired at t=%0t", $time);
      $fatal(1, "time limit");
   end

   initial begin
      rst = 1'b1;
      cmd_start = 1'b0;
      cmd_abort = 1'b0;
      x_tvalid = 1'b0;
      x_tready = 1'b0;
      layer_done = 3'b000;
      class_in = 4'd0;
      test_reset();
      test_nominal(4'd7);
      test_short_image();
      test_long_image();
      test_abort();
      test_reset_spurious();
      test_watchdog();
      total++;
      if (exp_ls_q.size() != 0 || exp_cls_q.size() != 0) begin
         bad++;
         $display("FAIL missing_pulses got ls_left=%0d cls_left=%0d want 0 0", exp_ls_q.size(), exp_cls_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
